// File: rtl/regs_file.sv
// RV32I integer register file: 31 stored registers (x0 reads as zero), two read ports, one write port.
// Read data is registered. A write to the register being read in the same cycle is returned on that read.
module regs_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rs_rd_en,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] rd_wr_data,
   input  logic                  rd_wr_en,
   output logic [DATA_WIDTH-1:0] rs1_rd_data,
   output logic [DATA_WIDTH-1:0] rs2_rd_data
);

   localparam int REG_COUNT = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] x [1:REG_COUNT-1];
   logic [REG_COUNT-1:1]  wr_sel;

   logic [DATA_WIDTH-1:0] rs1_rd_data_reg, rs1_rd_data_next;
   logic [DATA_WIDTH-1:0] rs2_rd_data_reg, rs2_rd_data_next;

   // One-hot write decode; index 0 has no slot, so writes to x0 fall away naturally.
   genvar gi;
   generate
      for (gi = 1; gi < REG_COUNT; gi++) begin : g_wr_sel
         assign wr_sel[gi] = rd_wr_en && (rd == ADDR_WIDTH'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < REG_COUNT; i++) begin
            x[i] <= '0;
         end
      end else begin
         for (int i = 1; i < REG_COUNT; i++) begin
            if (wr_sel[i]) begin
               x[i] <= rd_wr_data;
            end
         end
      end
   end

   // Each port independently: x0 reads zero, a same-edge write wins over the stored value.
   always_comb begin
      rs1_rd_data_next = rs1_rd_data_reg;
      rs2_rd_data_next = rs2_rd_data_reg;
      if (rs_rd_en) begin
         if (rs1 == '0) begin
            rs1_rd_data_next = '0;
         end else if (rd_wr_en && (rd == rs1)) begin
            rs1_rd_data_next = rd_wr_data;
         end else begin
            rs1_rd_data_next = x[rs1];
         end

         if (rs2 == '0) begin
            rs2_rd_data_next = '0;
         end else if (rd_wr_en && (rd == rs2)) begin
            rs2_rd_data_next = rd_wr_data;
         end else begin
            rs2_rd_data_next = x[rs2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rs1_rd_data_reg <= '0;
         rs2_rd_data_reg <= '0;
      end else begin
         rs1_rd_data_reg <= rs1_rd_data_next;
         rs2_rd_data_reg <= rs2_rd_data_next;
      end
   end

   assign rs1_rd_data = rs1_rd_data_reg;
   assign rs2_rd_data = rs2_rd_data_reg;

endmodule

// File: tb/tb_regs_file.sv
// Directed bench for regs_file: reset, write sweep and paired reads, x0 protection,
// write-first bypass, read-enable hold and reset colliding with a write.
module tb_regs_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        rs_rd_en;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rd_wr_data;
   logic        rd_wr_en;
   logic [31:0] rs1_rd_data, rs2_rd_data;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_mem [0:31];

   regs_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .rs_rd_en    (rs_rd_en),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .rd_wr_data  (rd_wr_data),
      .rd_wr_en    (rd_wr_en),
      .rs1_rd_data (rs1_rd_data),
      .rs2_rd_data (rs2_rd_data)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
      end
   endtask

   initial begin
      rst        = 1'b1;
      rs_rd_en   = 1'b0;
      rs1        = '0;
      rs2        = '0;
      rd         = '0;
      rd_wr_data = '0;
      rd_wr_en   = 1'b0;

      // Reset held for 5 cycles
      repeat (5) tick();
      rst = 1'b0;
      check("reset_rs1", rs1_rd_data, 32'h0);
      check("reset_rs2", rs2_rd_data, 32'h0);
      for (int i = 1; i < 32; i++) begin
         check($sformatf("reset_x%0d", i), dut.x[i], 32'h0);
      end
      $display("reset released: outputs and x[1..31] checked");

      // Write sweep over all 32 indices, x0 write must be discarded
      exp_mem[0] = 32'h0;
      for (int i = 0; i < 32; i++) begin
         logic [31:0] v;
         v          = $urandom();
         rd_wr_en   = 1'b1;
         rd         = 5'(i);
         rd_wr_data = v;
         tick();
         if (i != 0) exp_mem[i] = v;
         $display("write x%0d <= %08h", i, v);
      end
      rd_wr_en = 1'b0;

      // Paired reads (0,1) .. (30,31)
      for (int p = 0; p < 16; p++) begin
         rs1      = 5'(2 * p);
         rs2      = 5'(2 * p + 1);
         rs_rd_en = 1'b1;
         tick();
         check($sformatf("sweep_rs1_x%0d", 2 * p), rs1_rd_data, exp_mem[2 * p]);
         check($sformatf("sweep_rs2_x%0d", 2 * p + 1), rs2_rd_data, exp_mem[2 * p + 1]);
         $display("read x%0d=%08h x%0d=%08h", 2 * p, rs1_rd_data, 2 * p + 1, rs2_rd_data);
      end
      rs_rd_en = 1'b0;

      // x0 protection
      rd_wr_en   = 1'b1;
      rd         = 5'd0;
      rd_wr_data = 32'hDEADBEEF;
      tick();
      rd_wr_en = 1'b0;
      rs1      = 5'd0;
      rs2      = 5'd0;
      rs_rd_en = 1'b1;
      tick();
      rs_rd_en = 1'b0;
      check("x0_rs1", rs1_rd_data, 32'h0);
      check("x0_rs2", rs2_rd_data, 32'h0);
      $display("x0 write DEADBEEF then read: rs1=%08h rs2=%08h", rs1_rd_data, rs2_rd_data);

      // Bypass on port 1, stored value on port 2
      rd_wr_en   = 1'b1;
      rd         = 5'd6;
      rd_wr_data = 32'hA5A5A5A5;
      tick();
      rd         = 5'd5;
      rd_wr_data = 32'h12345678;
      rs1        = 5'd5;
      rs2        = 5'd6;
      rs_rd_en   = 1'b1;
      tick();
      rd_wr_en = 1'b0;
      rs_rd_en = 1'b0;
      check("bypass_rs1", rs1_rd_data, 32'h12345678);
      check("bypass_rs2", rs2_rd_data, 32'hA5A5A5A5);
      check("bypass_x5_stored", dut.x[5], 32'h12345678);
      $display("bypass write x5 while reading x5,x6: rs1=%08h rs2=%08h", rs1_rd_data, rs2_rd_data);

      // Bypass on both ports reading the same register
      rd_wr_en   = 1'b1;
      rd         = 5'd9;
      rd_wr_data = 32'h0BADF00D;
      rs1        = 5'd9;
      rs2        = 5'd9;
      rs_rd_en   = 1'b1;
      tick();
      rd_wr_en = 1'b0;
      rs_rd_en = 1'b0;
      check("bypass_both_rs1", rs1_rd_data, 32'h0BADF00D);
      check("bypass_both_rs2", rs2_rd_data, 32'h0BADF00D);
      $display("bypass write x9 while reading x9,x9: rs1=%08h rs2=%08h", rs1_rd_data, rs2_rd_data);

      // Hold with rs_rd_en low
      rd_wr_en   = 1'b1;
      rd         = 5'd3;
      rd_wr_data = 32'h00000003;
      tick();
      rd_wr_en = 1'b0;
      rs1      = 5'd3;
      rs2      = 5'd5;
      rs_rd_en = 1'b1;
      tick();
      check("hold_read_x3", rs1_rd_data, 32'h00000003);
      rs_rd_en = 1'b0;
      rs1      = 5'd4;
      rs2      = 5'd6;
      tick();
      tick();
      check("hold_rs1", rs1_rd_data, 32'h00000003);
      check("hold_rs2", rs2_rd_data, 32'h12345678);
      $display("hold with rd_en low: rs1=%08h rs2=%08h", rs1_rd_data, rs2_rd_data);

      // Reset colliding with a write and a read
      rst        = 1'b1;
      rd_wr_en   = 1'b1;
      rd         = 5'd7;
      rd_wr_data = 32'hFFFFFFFF;
      rs1        = 5'd7;
      rs2        = 5'd3;
      rs_rd_en   = 1'b1;
      tick();
      rst      = 1'b0;
      rd_wr_en = 1'b0;
      rs_rd_en = 1'b0;
      check("rst_write_x7", dut.x[7], 32'h0);
      check("rst_write_x3", dut.x[3], 32'h0);
      check("rst_write_rs1", rs1_rd_data, 32'h0);
      check("rst_write_rs2", rs2_rd_data, 32'h0);
      $display("reset with write x7: x7=%08h rs1=%08h rs2=%08h", dut.x[7], rs1_rd_data, rs2_rd_data);

      // Register file still usable after reset
      rd_wr_en   = 1'b1;
      rd         = 5'd31;
      rd_wr_data = 32'hCAFE0031;
      tick();
      rd_wr_en = 1'b0;
      rs1      = 5'd7;
      rs2      = 5'd31;
      rs_rd_en = 1'b1;
      tick();
      rs_rd_en = 1'b0;
      check("post_rst_x7", rs1_rd_data, 32'h0);
      check("post_rst_x31", rs2_rd_data, 32'hCAFE0031);
      $display("post-reset read x7=%08h x31=%08h", rs1_rd_data, rs2_rd_data);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
